// File: rtl/dsa_csr_bank_v2.sv
// rtl/dsa_csr_bank_v2.sv - Control/status register bank for the bilinear-interpolation DSA
// Staged config committed on start, W1C interrupts, registered reads, cycle snapshot.
module dsa_csr_bank_v2 #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 16,
  parameter int          REG_BYTES = 64,
  parameter logic [31:0] VERSION   = 32'h0200_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  reg_hit,
  output logic [15:0]           cfg_width,
  output logic [15:0]           cfg_height,
  output logic [15:0]           cfg_scale_q8_8,
  output logic                  cfg_mode_simd,
  output logic [5:0]            cfg_simd_idx,
  output logic [7:0]            cfg_simd_n,
  output logic                  cfg_start,
  output logic                  cfg_soft_reset,
  output logic                  cfg_clear_errors,
  output logic                  irq,
  input  logic                  status_busy,
  input  logic                  status_done,
  input  logic                  status_error,
  input  logic [7:0]            status_progress,
  input  logic [15:0]           err_code,
  input  logic [31:0]           cycle_count
);

  localparam int NB = DATA_W / 8;
  localparam logic [1:0] LANE_MASK = 2'(~(NB - 1));

  localparam logic [ADDR_W-3:0] W_WIDTH  = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] W_HEIGHT = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] W_SCALE  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] W_CTRL   = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] W_STATUS = (ADDR_W-2)'(4);
  localparam logic [ADDR_W-3:0] W_SIMDN  = (ADDR_W-2)'(5);
  localparam logic [ADDR_W-3:0] W_IRQS   = (ADDR_W-2)'(6);
  localparam logic [ADDR_W-3:0] W_IRQEN  = (ADDR_W-2)'(7);
  localparam logic [ADDR_W-3:0] W_CYC    = (ADDR_W-2)'(8);
  localparam logic [ADDR_W-3:0] W_SCR    = (ADDR_W-2)'(9);
  localparam logic [ADDR_W-3:0] W_VER    = (ADDR_W-2)'(10);

  logic [15:0] st_width, st_height, st_scale;
  logic        st_simd;
  logic [5:0]  st_idx;
  logic [7:0]  st_simd_n;
  logic [2:0]  irq_status, irq_en;
  logic [31:0] scratch, snap;
  logic        done_q, err_q;

  logic [15:0] st_width_n, st_height_n, st_scale_n;
  logic        st_simd_n_bit;
  logic [5:0]  st_idx_n;
  logic [7:0]  st_simd_n_n;
  logic [2:0]  irq_en_n, irq_set, irq_clr;

  logic [ADDR_W-3:0] word;
  logic [1:0]        base;
  logic [3:0]        wmask;
  logic [31:0]       wd32, m32, rword, wr_word;
  logic [DATA_W-1:0] rd_lanes;
  logic              wr_hit, start_wr, accept, reject, soft_wr, clr_wr, snap_load;

  assign reg_hit = addr < ADDR_W'(REG_BYTES);
  assign word    = addr[ADDR_W-1:2];
  assign base    = addr[1:0] & LANE_MASK;
  assign wr_hit  = wr_en & reg_hit;

  // Host lanes land on consecutive bytes of one 32-bit word since accesses are aligned.
  always_comb begin
    wmask    = '0;
    wd32     = '0;
    rd_lanes = '0;
    for (int i = 0; i < NB; i++) begin
      wmask[base + 2'(i)]                 = wstrb[i] & wr_hit;
      wd32[{base + 2'(i), 3'b000} +: 8]   = wdata[8*i +: 8];
      rd_lanes[8*i +: 8]                  = rword[{base + 2'(i), 3'b000} +: 8];
    end
  end

  assign m32 = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

  always_comb begin
    rword = '0;
    if (reg_hit) begin
      case (word)
        W_WIDTH:  rword = {16'b0, st_width};
        W_HEIGHT: rword = {16'b0, st_height};
        W_SCALE:  rword = {16'b0, st_scale};
        W_CTRL:   rword = {24'b0, st_idx, st_simd, 1'b0};
        W_STATUS: rword = {err_code, status_progress, 5'b0, status_error, status_done, status_busy};
        W_SIMDN:  rword = {24'b0, st_simd_n};
        W_IRQS:   rword = {29'b0, irq_status};
        W_IRQEN:  rword = {29'b0, irq_en};
        W_CYC:    rword = (base == 2'b00) ? cycle_count : snap;
        W_SCR:    rword = scratch;
        W_VER:    rword = VERSION;
        default:  rword = '0;
      endcase
    end
  end

  // Merge written bytes over the register's read view; pulse bits read 0, so they carry the written value.
  assign wr_word = (rword & ~m32) | (wd32 & m32);

  always_comb begin
    st_width_n    = (wr_hit && word == W_WIDTH)  ? wr_word[15:0] : st_width;
    st_height_n   = (wr_hit && word == W_HEIGHT) ? wr_word[15:0] : st_height;
    st_scale_n    = (wr_hit && word == W_SCALE)  ? wr_word[15:0] : st_scale;
    st_simd_n_bit = (wr_hit && word == W_CTRL)   ? wr_word[1]    : st_simd;
    st_idx_n      = (wr_hit && word == W_CTRL)   ? wr_word[7:2]  : st_idx;
    st_simd_n_n   = (wr_hit && word == W_SIMDN)  ? wr_word[7:0]  : st_simd_n;
    irq_en_n      = (wr_hit && word == W_IRQEN)  ? wr_word[2:0]  : irq_en;
    irq_clr       = (wr_hit && word == W_IRQS)   ? (wd32[2:0] & {3{wmask[0]}}) : 3'b000;
  end

  assign start_wr  = wr_hit && word == W_CTRL && wr_word[0];
  assign soft_wr   = wr_hit && word == W_CTRL && wr_word[8];
  assign clr_wr    = wr_hit && word == W_CTRL && wr_word[9];
  assign accept    = start_wr & ~status_busy;
  assign reject    = start_wr & status_busy;
  assign irq_set   = {reject, status_error & ~err_q, status_done & ~done_q};
  assign snap_load = rd_en && reg_hit && word == W_CYC && base == 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_width         <= 16'd256;
      st_height        <= 16'd256;
      st_scale         <= 16'h00C0;
      st_simd          <= 1'b0;
      st_idx           <= '0;
      st_simd_n        <= 8'd1;
      cfg_width        <= 16'd256;
      cfg_height       <= 16'd256;
      cfg_scale_q8_8   <= 16'h00C0;
      cfg_mode_simd    <= 1'b0;
      cfg_simd_idx     <= '0;
      cfg_simd_n       <= 8'd1;
      cfg_start        <= 1'b0;
      cfg_soft_reset   <= 1'b0;
      cfg_clear_errors <= 1'b0;
      irq_status       <= '0;
      irq_en           <= '0;
      irq              <= 1'b0;
      scratch          <= '0;
      snap             <= '0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      rdata            <= '0;
      rvalid           <= 1'b0;
    end else begin
      st_width  <= st_width_n;
      st_height <= st_height_n;
      st_scale  <= st_scale_n;
      st_simd   <= st_simd_n_bit;
      st_idx    <= st_idx_n;
      st_simd_n <= st_simd_n_n;
      irq_en    <= irq_en_n;
      if (wr_hit && word == W_SCR) scratch <= wr_word;
      if (accept) begin
        cfg_width      <= st_width_n;
        cfg_height     <= st_height_n;
        cfg_scale_q8_8 <= st_scale_n;
        cfg_mode_simd  <= st_simd_n_bit;
        cfg_simd_idx   <= st_idx_n;
        cfg_simd_n     <= st_simd_n_n;
      end
      cfg_start        <= accept;
      cfg_soft_reset   <= soft_wr;
      cfg_clear_errors <= clr_wr;
      done_q           <= status_done;
      err_q            <= status_error;
      // Set has priority over a simultaneous W1C of the same bit.
      irq_status       <= (irq_status & ~irq_clr) | irq_set;
      irq              <= |(irq_status & irq_en);
      rvalid           <= rd_en;
      if (rd_en) rdata <= rd_lanes;
      if (snap_load) snap <= cycle_count;
    end
  end

endmodule

// File: tb/tb_dsa_csr_bank_v2.sv
// tb/tb_dsa_csr_bank_v2.sv - Directed bench for dsa_csr_bank_v2 (32-bit and 8-bit builds)
module tb_dsa_csr_bank_v2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] rdata;
  logic        rvalid, reg_hit;
  logic [15:0] cfg_width, cfg_height, cfg_scale_q8_8;
  logic        cfg_mode_simd;
  logic [5:0]  cfg_simd_idx;
  logic [7:0]  cfg_simd_n;
  logic        cfg_start, cfg_soft_reset, cfg_clear_errors, irq;
  logic        status_busy = 1'b0, status_done = 1'b0, status_error = 1'b0;
  logic [7:0]  status_progress = 8'd0;
  logic [15:0] err_code = 16'd0;
  logic [31:0] cycle_count = 32'd0;

  logic [15:0] addr8 = '0;
  logic [7:0]  wdata8 = '0;
  logic [0:0]  wstrb8 = '0;
  logic        wr_en8 = 1'b0, rd_en8 = 1'b0;
  logic [7:0]  rdata8;
  logic        rvalid8, reg_hit8;
  logic [15:0] w8, h8, s8;
  logic        simd8;
  logic [5:0]  idx8;
  logic [7:0]  n8;
  logic        start8, soft8, clr8, irq8;
  logic [31:0] cyc8 = 32'd0;

  int errors = 0;
  int checks = 0;

  dsa_csr_bank_v2 u_dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .reg_hit(reg_hit),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_scale_q8_8(cfg_scale_q8_8),
    .cfg_mode_simd(cfg_mode_simd), .cfg_simd_idx(cfg_simd_idx), .cfg_simd_n(cfg_simd_n),
    .cfg_start(cfg_start), .cfg_soft_reset(cfg_soft_reset), .cfg_clear_errors(cfg_clear_errors),
    .irq(irq), .status_busy(status_busy), .status_done(status_done), .status_error(status_error),
    .status_progress(status_progress), .err_code(err_code), .cycle_count(cycle_count)
  );

  dsa_csr_bank_v2 #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .addr(addr8), .wdata(wdata8), .wstrb(wstrb8),
    .wr_en(wr_en8), .rd_en(rd_en8), .rdata(rdata8), .rvalid(rvalid8), .reg_hit(reg_hit8),
    .cfg_width(w8), .cfg_height(h8), .cfg_scale_q8_8(s8),
    .cfg_mode_simd(simd8), .cfg_simd_idx(idx8), .cfg_simd_n(n8),
    .cfg_start(start8), .cfg_soft_reset(soft8), .cfg_clear_errors(clr8),
    .irq(irq8), .status_busy(1'b0), .status_done(1'b0), .status_error(1'b0),
    .status_progress(8'd0), .err_code(16'd0), .cycle_count(cyc8)
  );

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); addr = a; wdata = d; wstrb = s; wr_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0; wstrb = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic v);
    @(negedge clk); addr = a; rd_en = 1'b1;
    @(posedge clk); #1; rd_en = 1'b0; d = rdata; v = rvalid;
  endtask

  task automatic rd8(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk); addr8 = a; rd_en8 = 1'b1;
    @(posedge clk); #1; rd_en8 = 1'b0; d = rdata8;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic v;
    @(posedge clk); #1;
    checks++; if ({cfg_width, cfg_height, cfg_scale_q8_8, cfg_simd_n} !== {16'd256, 16'd256, 16'h00C0, 8'd1}) begin
      errors++; $display("FAIL reset_cfg got=%h %h %h %h exp=0100 0100 00c0 01", cfg_width, cfg_height, cfg_scale_q8_8, cfg_simd_n); end
    checks++; if ({irq, rvalid, cfg_start, cfg_mode_simd, rdata} !== 36'd0) begin
      errors++; $display("FAIL reset_misc got irq=%b rvalid=%b start=%b simd=%b rdata=%h exp=0", irq, rvalid, cfg_start, cfg_mode_simd, rdata); end
    @(negedge clk); reset = 1'b0;
    rd(16'h00, d, v);
    checks++; if (d !== 32'h100 || v !== 1'b1) begin errors++; $display("FAIL rd_width got=%h/%b exp=00000100/1", d, v); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle got=%b exp=0", rvalid); end
    rd(16'h08, d, v);
    checks++; if (d !== 32'hC0 || v !== 1'b1) begin errors++; $display("FAIL rd_scale got=%h/%b exp=000000c0/1", d, v); end
    rd(16'h14, d, v);
    checks++; if (d !== 32'h1 || v !== 1'b1) begin errors++; $display("FAIL rd_simdn got=%h/%b exp=00000001/1", d, v); end
    rd(16'h28, d, v);
    checks++; if (d !== 32'h0200_0000 || v !== 1'b1) begin errors++; $display("FAIL rd_version got=%h/%b exp=02000000/1", d, v); end
  endtask

  task automatic test_strobe_and_start;
    logic [31:0] d; logic v;
    wr(16'h00, 32'h0280, 4'b0001);
    rd(16'h00, d, v);
    checks++; if (d !== 32'h0180) begin errors++; $display("FAIL strobe_partial got=%h exp=00000180", d); end
    checks++; if (cfg_width !== 16'd256) begin errors++; $display("FAIL active_hold got=%0d exp=256", cfg_width); end
    wr(16'h00, 32'd640, 4'b1111);
    wr(16'h0C, 32'h3, 4'b1111);
    checks++; if ({cfg_start, cfg_width, cfg_mode_simd} !== {1'b1, 16'd640, 1'b1}) begin
      errors++; $display("FAIL start_commit got start=%b width=%0d simd=%b exp=1 640 1", cfg_start, cfg_width, cfg_mode_simd); end
    @(posedge clk); #1;
    checks++; if (cfg_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got=%b exp=0", cfg_start); end
  endtask

  task automatic test_reject_irq;
    logic [31:0] d; logic v;
    wr(16'h1C, 32'h4, 4'b1111);
    status_busy = 1'b1;
    wr(16'h00, 32'd100, 4'b1111);
    wr(16'h0C, 32'h1, 4'b1111);
    checks++; if ({cfg_start, cfg_width, cfg_mode_simd, irq} !== {1'b0, 16'd640, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reject_hold got start=%b width=%0d simd=%b irq=%b exp=0 640 1 0", cfg_start, cfg_width, cfg_mode_simd, irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
    status_busy = 1'b0;
    rd(16'h18, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL irq_status_rej got=%h exp=00000004", d); end
    wr(16'h18, 32'h4, 4'b1111);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", irq); end
    rd(16'h18, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_status_clr got=%h exp=00000000", d); end
  endtask

  task automatic test_w1c_race;
    logic [31:0] d; logic v;
    @(negedge clk); status_done = 1'b1; addr = 16'h18; wdata = 32'h1; wstrb = 4'hF; wr_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0; wstrb = '0;
    rd(16'h18, d, v);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL set_wins got=%h exp=00000001", d); end
    wr(16'h18, 32'h1, 4'b1111);
    rd(16'h18, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_no_reset got=%h exp=00000000", d); end
    status_done = 1'b0;
  endtask

  task automatic test_pulses_scratch;
    logic [31:0] d; logic v;
    wr(16'h0C, 32'h300, 4'b1111);
    checks++; if ({cfg_soft_reset, cfg_clear_errors, cfg_start} !== 3'b110) begin
      errors++; $display("FAIL pulses_high got soft=%b clr=%b start=%b exp=1 1 0", cfg_soft_reset, cfg_clear_errors, cfg_start); end
    @(posedge clk); #1;
    checks++; if ({cfg_soft_reset, cfg_clear_errors} !== 2'b00) begin
      errors++; $display("FAIL pulses_low got soft=%b clr=%b exp=0 0", cfg_soft_reset, cfg_clear_errors); end
    rd(16'h0C, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_readback got=%h exp=00000000", d); end
    wr(16'h24, 32'hDEAD_BEEF, 4'b1111);
    rd(16'h24, d, v);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch got=%h exp=deadbeef", d); end
    @(negedge clk); addr = 16'h40; #1;
    checks++; if (reg_hit !== 1'b0) begin errors++; $display("FAIL reg_hit_out got=%b exp=0", reg_hit); end
    wr(16'h40, 32'h5555_5555, 4'b1111);
    rd(16'h40, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL rd_outside got=%h/%b exp=00000000/1", d, v); end
  endtask

  task automatic test_cyc;
    logic [31:0] d; logic v; logic [7:0] b;
    cycle_count = 32'h1234_5678;
    rd(16'h20, d, v);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL cyc32 got=%h exp=12345678", d); end
    cyc8 = 32'h1122_3344;
    rd8(16'h20, b);
    checks++; if (b !== 8'h44) begin errors++; $display("FAIL cyc8_b0 got=%h exp=44", b); end
    cyc8 = 32'hAABB_CCDD;
    rd8(16'h21, b);
    checks++; if (b !== 8'h33) begin errors++; $display("FAIL cyc8_b1 got=%h exp=33", b); end
    rd8(16'h22, b);
    checks++; if (b !== 8'h22) begin errors++; $display("FAIL cyc8_b2 got=%h exp=22", b); end
    rd8(16'h23, b);
    checks++; if (b !== 8'h11) begin errors++; $display("FAIL cyc8_b3 got=%h exp=11", b); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d; logic v;
    wr(16'h1C, 32'h1, 4'b1111);
    @(negedge clk); status_done = 1'b1;
    @(negedge clk); status_done = 1'b0;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    wr(16'h04, 32'd77, 4'b1111);
    @(negedge clk); reset = 1'b1; addr = 16'h0C; wdata = 32'h303; wstrb = 4'hF; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0; rd_en = 1'b0; wstrb = '0; reset = 1'b0;
    checks++; if ({cfg_start, cfg_soft_reset, cfg_clear_errors, irq, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got start=%b soft=%b clr=%b irq=%b rvalid=%b exp=0", cfg_start, cfg_soft_reset, cfg_clear_errors, irq, rvalid); end
    checks++; if ({cfg_width, cfg_mode_simd, rdata} !== {16'd256, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_active got width=%0d simd=%b rdata=%h exp=256 0 0", cfg_width, cfg_mode_simd, rdata); end
    rd(16'h04, d, v);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL reset_staging got=%h exp=00000100", d); end
  endtask

  initial begin
    test_reset();
    test_strobe_and_start();
    test_reject_irq();
    test_w1c_race();
    test_pulses_scratch();
    test_cyc();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsa_csr_bank_v2.md
Name: dsa_csr_bank_v2

Overview:
Second-generation memory-mapped control/status bank for the bilinear-interpolation DSA. It sits between the host bus and the DSA core. It provides:
- a parametrised host data width with byte strobes;
- a registered read path;
- staged (shadow) configuration committed atomically on start;
- start rejection while busy;
- a W1C interrupt status with enable mask and irq output;
- a tear-free 32-bit cycle-counter snapshot.

Parameters:
DATA_W, 32, host bus width in bits; legal values 8, 16, 32
ADDR_W, 16, host byte-address width
REG_BYTES, 64, size of register window in bytes (power of two, >=64)
VERSION, 32'h0200_0000, value returned at offset 0x28

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored (aligned access)
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte write enables
wr_en  in  1  write strobe
rd_en  in  1  read strobe
rdata  out  DATA_W  read data, valid when rvalid
rvalid  out  1  read-data valid, one cycle after rd_en
reg_hit  out  1  combinational; addr inside [0, REG_BYTES)
cfg_width  out  16  active (committed) input width
cfg_height  out  16  active input height
cfg_scale_q8_8  out  16  active scale factor
cfg_mode_simd  out  1  active SIMD mode
cfg_simd_idx  out  6  active SIMD index
cfg_simd_n  out  8  active lane count
cfg_start  out  1  one-cycle start pulse
cfg_soft_reset  out  1  one-cycle pulse
cfg_clear_errors  out  1  one-cycle pulse
irq  out  1  registered interrupt request
status_busy  in  1  core busy
status_done  in  1  core done pulse/level; rising edge counts
status_error  in  1  core error; rising edge counts
status_progress  in  8  0-100
err_code  in  16  diagnostic code
cycle_count  in  32  free-running core cycle counter

Behaviour:
- Register map (byte offsets, 32-bit words, little-endian; unused bits read 0, writes ignored):
  - 0x00 WIDTH[15:0] staging, RW
  - 0x04 HEIGHT[15:0] staging, RW
  - 0x08 SCALE[15:0] staging, RW
  - 0x0C CTRL:
    - [0] start, write-1 pulse
    - [1] simd, RW
    - [7:2] idx, RW
    - [8] soft_reset, W1 pulse
    - [9] clear_errors, W1 pulse
    - bits 0, 8 and 9 always read 0
  - 0x10 STATUS RO = {err_code, status_progress, 5'b0, status_error, status_done, status_busy}
  - 0x14 SIMD_N[7:0] staging, RW
  - 0x18 IRQ_STATUS W1C: [0] done, [1] error, [2] start_rejected
  - 0x1C IRQ_EN[2:0] RW
  - 0x20 CYC, RO cycle snapshot
  - 0x24 SCRATCH[31:0] RW
  - 0x28 VERSION RO
  - 0x2C..REG_BYTES-1 read 0, writes ignored
- Reset values:
  - staging and active: width/height 256, scale 0x00C0, simd 0, idx 0, simd_n 1
  - IRQ_STATUS 0, IRQ_EN 0, SCRATCH 0, snapshot 0
  - all pulse outputs 0, irq 0, rdata 0, rvalid 0
- Writes: each byte lane i with wstrb[i]=1 writes byte addr_aligned+i. Writes outside the register window are ignored.
- Start:
  - A write of 1 to CTRL[0] with status_busy=0 produces cfg_start=1 in the next cycle.
  - In that same cycle, all staging values (including the same write's CTRL[7:1]) are copied to the active cfg_* outputs.
  - Active outputs change only on an accepted start or on reset.
  - If status_busy=1: no pulse, no commit, IRQ_STATUS[2] is set.
- soft_reset and clear_errors pulse for exactly one cycle, the cycle after the write. They do not clear registers.
- IRQ_STATUS set sources:
  - bit0: rising edge of status_done
  - bit1: rising edge of status_error
  - bit2: rejected start
  - Edge detectors use registered previous values; the previous values are 0 after reset.
- IRQ_STATUS clearing: writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq is registered: irq <= |(IRQ_STATUS & IRQ_EN). It rises one cycle after the bit is set.
- Reads:
  - rdata/rvalid are registered; latency is 1.
  - Reads outside the register window return 0 with rvalid=1.
  - rd_en and wr_en together to the same address: the read returns the pre-write value.
- CYC snapshot:
  - A read whose lanes include byte 0x20 returns live cycle_count for those lanes and latches the full cycle_count into the snapshot.
  - Reads of 0x21-0x23 that do not include 0x20 return snapshot bytes.
  - For DATA_W=32 this is a single atomic read.
- Reset mid-operation returns everything to the reset values in the next cycle. Pending pulses are dropped.

Test Plan:
- Reset, then read 0x00/0x08/0x14/0x28 -> 0x100, 0xC0, 0x1, VERSION; rvalid exactly 1 cycle after each rd_en.
- Write WIDTH=640 with wstrb=4'b0001 only (wdata=0x0280) -> staging reads 0x0180 and cfg_width stays 256; full write 640 then CTRL=0x3 with busy=0 -> cfg_start pulse one cycle, cfg_width=640, cfg_mode_simd=1 on the same cycle.
- busy=1, write CTRL=0x1 -> no cfg_start, active outputs unchanged, IRQ_STATUS=0x4; with IRQ_EN=0x4, irq=1 one cycle after the set; write 0x4 to 0x18 -> IRQ_STATUS=0, irq=0 the next cycle.
- status_done 0→1 in the same cycle as a W1C write of 0x1 -> bit0 remains 1.
- DATA_W=8 build: cycle_count=0x11223344, read 0x20 (returns 0x44), change cycle_count to 0xAABBCCDD, read 0x21/0x22/0x23 -> 0x33, 0x22, 0x11.
- Write CTRL=0x300 -> cfg_soft_reset and cfg_clear_errors both high exactly one cycle; read CTRL -> 0x000; assert reset mid-sequence -> all outputs at reset values the next cycle.
